// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared types for the ALU issue stage.
// Holds widths, ALU op codes, FSM states and the instruction bundle.
package alu_issue_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;
  localparam int IDX_W  = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_LT  = 3'b110,
    OP_GT  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [IDX_W-1:0] rd;
    logic [IDX_W-1:0] rs1;
    logic [IDX_W-1:0] rs2;
    logic             imm_en;
    logic [DATA_W-1:0] imm;
  } instr_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: power-of-two instruction buffer of instr_t.
// Pointers wrap naturally; push is refused when full, pop when empty.
module alu_issue_fifo
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  instr_t                     din,
  input  logic                       pop,
  output instr_t                     dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  instr_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue stage that drives the 4-bit ALU and writes back.
// Optional sticky overflow flag via ALU_ISSUE_STICKY_OVF_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int NREGS      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_op,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic [$clog2(NREGS)-1:0] in_rs1,
  input  logic [$clog2(NREGS)-1:0] in_rs2,
  input  logic                     in_imm_en,
  input  logic [DATA_W-1:0]        in_imm,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [OP_W-1:0]          alu_ctrl,
  output logic                     alu_enable,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic                     alu_zero,
  input  logic                     alu_overflow,
  output logic                     flag_zero,
  output logic                     flag_ovf,
  input  logic                     clr_ovf,
  output logic                     busy,
  output logic [7:0]               retired,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int RW = $clog2(NREGS);

  state_e              state_q;
  state_e              state_d;
  instr_t              push_instr;
  instr_t              head;
  instr_t              iss;
  logic                pop;
  logic                full;
  logic                empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [DATA_W-1:0]   res_q;
  logic                res_zero_q;
  logic                res_ovf_q;
  logic [DATA_W-1:0]   regfile [NREGS];
  logic                unused;

  assign push_instr.op     = op_e'(in_op);
  assign push_instr.rd     = IDX_W'(in_rd);
  assign push_instr.rs1    = IDX_W'(in_rs1);
  assign push_instr.rs2    = IDX_W'(in_rs2);
  assign push_instr.imm_en = in_imm_en;
  assign push_instr.imm    = in_imm;

  assign in_ready = !full;
  assign busy     = (state_q != IDLE) || !empty;
  assign dbg_data = regfile[dbg_sel];

  alu_issue_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (push_instr),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, FIFO pop and ALU drive; ALU side is quiet outside EXEC.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = '0;
    alu_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = EXEC;
          pop     = 1'b1;
        end
      end
      EXEC: begin
        state_d    = WB;
        alu_a      = regfile[iss.rs1[RW-1:0]];
        alu_b      = iss.imm_en ? iss.imm
                                : regfile[iss.rs2[RW-1:0]];
        alu_ctrl   = iss.op;
        alu_enable = 1'b1;
      end
      WB: begin
        if (!empty) begin
          state_d = EXEC;
          pop     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue register loads the FIFO head on every pop.
  always_ff @(posedge clk) begin
    if (rst)      iss <= '0;
    else if (pop) iss <= head;
  end

  // Capture ALU outputs at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q      <= '0;
      res_zero_q <= 1'b0;
      res_ovf_q  <= 1'b0;
    end else if (state_q == EXEC) begin
      res_q      <= alu_result;
      res_zero_q <= alu_zero;
      res_ovf_q  <= alu_overflow;
    end
  end

  // Writeback: regfile, flags and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regfile[i] <= '0;
      flag_zero <= 1'b0;
      flag_ovf  <= 1'b0;
      retired   <= '0;
    end else begin
      if (state_q == WB) begin
        regfile[iss.rd[RW-1:0]] <= res_q;
        flag_zero <= res_zero_q;
        retired   <= retired + 8'd1;
      end
`ifdef ALU_ISSUE_STICKY_OVF_EN
      flag_ovf <= (clr_ovf ? 1'b0 : flag_ovf)
                | ((state_q == WB) && res_ovf_q);
`else
      if (state_q == WB) flag_ovf <= res_ovf_q;
`endif
    end
  end

`ifdef ALU_ISSUE_STICKY_OVF_EN
  assign unused = ^{iss.rd, iss.rs1, iss.rs2, fifo_count};
`else
  assign unused = ^{iss.rd, iss.rs1, iss.rs2, fifo_count, clr_ovf};
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl.
// A behavioural 4-bit ALU answers the DUT combinationally.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs1;
  logic [1:0] in_rs2;
  logic       in_imm_en;
  logic [3:0] in_imm;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_ctrl;
  logic       alu_enable;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       alu_overflow;
  logic       flag_zero;
  logic       flag_ovf;
  logic       clr_ovf;
  logic       busy;
  logic [7:0] retired;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  logic [3:0] sum;
  logic [3:0] dif;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .NREGS      (4),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rd        (in_rd),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm_en    (in_imm_en),
    .in_imm       (in_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .alu_enable   (alu_enable),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .flag_zero    (flag_zero),
    .flag_ovf     (flag_ovf),
    .clr_ovf      (clr_ovf),
    .busy         (busy),
    .retired      (retired),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );

  // Behavioural ALU: signed overflow on add/sub only.
  always_comb begin
    sum          = alu_a + alu_b;
    dif          = alu_a - alu_b;
    alu_result   = 4'd0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      3'b000: begin
        alu_result   = sum;
        alu_overflow = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
      end
      3'b001: begin
        alu_result   = dif;
        alu_overflow = (alu_a[3] != alu_b[3]) && (dif[3] != alu_a[3]);
      end
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = ~alu_a;
      3'b110:  alu_result = {3'd0, alu_a < alu_b};
      default: alu_result = {3'd0, alu_a > alu_b};
    endcase
    alu_zero = (alu_result == 4'd0);
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2,
                        input logic ie, input logic [3:0] imm);
    in_valid  = 1'b1;
    in_op     = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm_en = ie;
    in_imm    = imm;
  endtask

  task automatic push(input logic [2:0] op, input logic [1:0] rd,
                      input logic [1:0] rs1, input logic [1:0] rs2,
                      input logic ie, input logic [3:0] imm);
    set_in(op, rd, rs1, rs2, ie, imm);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] idx,
                         input logic [3:0] exp);
    dbg_sel = idx;
    #1;
    chk(tag, {4'd0, dbg_data}, {4'd0, exp});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_imm_en = 1'b0; in_imm = '0;
    clr_ovf = 1'b0; dbg_sel = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_retired", retired, 8'd0);
    chk("rst_fz", {7'd0, flag_zero}, 8'd0);
    chk("rst_fo", {7'd0, flag_ovf}, 8'd0);
    chk("rst_en", {7'd0, alu_enable}, 8'd0);
    chk("rst_a", {4'd0, alu_a}, 8'd0);
    chk_reg("rst_r1", 2'd1, 4'd0);

    // add r1 = r0 + 3
    push(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'd3);
    chk("t1_nobypass_en", {7'd0, alu_enable}, 8'd0);
    chk("t1_busy", {7'd0, busy}, 8'd1);
    tick();
    chk("t1_exec_en", {7'd0, alu_enable}, 8'd1);
    chk("t1_exec_a", {4'd0, alu_a}, 8'd0);
    chk("t1_exec_b", {4'd0, alu_b}, 8'd3);
    chk("t1_exec_ctrl", {5'd0, alu_ctrl}, 8'd0);
    tick();
    chk("t1_wb_en", {7'd0, alu_enable}, 8'd0);
    tick();
    chk_reg("t1_r1", 2'd1, 4'd3);
    chk("t1_fz", {7'd0, flag_zero}, 8'd0);
    chk("t1_retired", retired, 8'd1);
    chk("t1_idle", {7'd0, busy}, 8'd0);

    // r1 = 7, then r2 = r1 + 1 overflows
    push(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'd7);
    tick(); tick(); tick();
    push(3'b000, 2'd2, 2'd1, 2'd0, 1'b1, 4'd1);
    tick(); tick(); tick();
    chk_reg("t2_r2", 2'd2, 4'd8);
    chk("t2_fo", {7'd0, flag_ovf}, 8'd1);
    chk("t2_retired", retired, 8'd3);

    // back-to-back dependent: r1 = 5, r3 = r1 - r1
    push(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5);
    push(3'b001, 2'd3, 2'd1, 2'd1, 1'b0, 4'd0);
    chk("t3_ready", {7'd0, in_ready}, 8'd1);
    tick(); tick();
    chk_reg("t3_r1", 2'd1, 4'd5);
    chk("t3_exec_a", {4'd0, alu_a}, 8'd5);
    chk("t3_exec_b", {4'd0, alu_b}, 8'd5);
    chk("t3_exec_ctrl", {5'd0, alu_ctrl}, 8'd1);
    tick(); tick();
    chk_reg("t3_r3", 2'd3, 4'd0);
    chk("t3_fz", {7'd0, flag_zero}, 8'd1);
    chk("t3_retired", retired, 8'd5);

    // fill the FIFO: fourth offer is held until a slot frees
    set_in(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'd1);
    tick();
    set_in(3'b000, 2'd2, 2'd0, 2'd0, 1'b1, 4'd2);
    tick();
    set_in(3'b000, 2'd3, 2'd0, 2'd0, 1'b1, 4'd3);
    tick();
    chk("t4_full", {7'd0, in_ready}, 8'd0);
    set_in(3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 4'd4);
    tick();
    chk("t4_ready_again", {7'd0, in_ready}, 8'd1);
    chk("t4_ret1", retired, 8'd6);
    chk_reg("t4_r1", 2'd1, 4'd1);
    tick();
    in_valid = 1'b0;
    chk("t4_full2", {7'd0, in_ready}, 8'd0);
    tick();
    chk("t4_ret2", retired, 8'd7);
    chk_reg("t4_r2", 2'd2, 4'd2);
    tick(); tick();
    chk("t4_ret3", retired, 8'd8);
    chk_reg("t4_r3", 2'd3, 4'd3);
    tick(); tick();
    chk("t4_ret4", retired, 8'd9);
    chk_reg("t4_r0", 2'd0, 4'd4);
    chk("t4_idle", {7'd0, busy}, 8'd0);

    // reset during EXEC of r1 = r0 + 9
    push(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'd9);
    tick();
    chk("t5_exec_en", {7'd0, alu_enable}, 8'd1);
    chk("t5_exec_a", {4'd0, alu_a}, 8'd4);
    chk("t5_exec_b", {4'd0, alu_b}, 8'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_retired", retired, 8'd0);
    chk("t5_busy", {7'd0, busy}, 8'd0);
    chk("t5_ready", {7'd0, in_ready}, 8'd1);
    chk("t5_en", {7'd0, alu_enable}, 8'd0);
    chk("t5_a", {4'd0, alu_a}, 8'd0);
    chk("t5_b", {4'd0, alu_b}, 8'd0);
    chk("t5_fo", {7'd0, flag_ovf}, 8'd0);
    chk_reg("t5_r1", 2'd1, 4'd0);
    tick(); tick();
    chk_reg("t5_r1_late", 2'd1, 4'd0);
    chk("t5_retired_late", retired, 8'd0);

    // overflow, then a clean add, then clr_ovf
    push(3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'd7);
    tick(); tick(); tick();
    push(3'b000, 2'd2, 2'd1, 2'd0, 1'b1, 4'd1);
    tick(); tick(); tick();
    chk("t6_fo_set", {7'd0, flag_ovf}, 8'd1);
    push(3'b000, 2'd3, 2'd0, 2'd0, 1'b1, 4'd1);
    tick(); tick(); tick();
    chk_reg("t6_r3", 2'd3, 4'd1);
`ifdef ALU_ISSUE_STICKY_OVF_EN
    chk("t6_fo_after", {7'd0, flag_ovf}, 8'd1);
`else
    chk("t6_fo_after", {7'd0, flag_ovf}, 8'd0);
`endif
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t6_fo_clr", {7'd0, flag_ovf}, 8'd0);
    chk("t6_retired", retired, 8'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
